perf_counter_reader: RTL and testbench

PERF_COUNTER_READER -- requirements
Module: perf_counter_reader

---
 rtl/lc3b_types.sv | 16 +
 rtl/perf_addr_decode.sv | 21 ++
 rtl/perf_counter_reader.sv | 125 ++++++++++++
 tb/tb_perf_counter_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the performance-counter register window.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CLEAR   = 2'd2,
        RESP    = 2'd3
    } perf_state_t;

    localparam lc3b_word   PERF_BASE_ADDR = 16'hFF00;
    localparam logic [3:0] PERF_ID_INDEX  = 4'hF;

endpackage

// File: rtl/perf_addr_decode.sv
// Combinational decode of a byte address into window hit and register index.
module perf_addr_decode
    import lc3b_types::*;
#(
    parameter int       NUM_COUNTERS = 8,
    parameter lc3b_word BASE_ADDR    = PERF_BASE_ADDR
) (
    input  lc3b_word    address,
    output logic        hit,
    output logic [3:0]  index,
    output logic        index_valid
);

    logic unused_byte_sel;

    assign hit             = (address[15:5] == BASE_ADDR[15:5]);
    assign index           = address[4:1];
    assign index_valid     = int'(index) < NUM_COUNTERS;
    assign unused_byte_sel = address[0];

endmodule

// File: rtl/perf_counter_reader.sv
// Memory-mapped reader/clearer for performance counters.
// Define PERF_CLEAR_ON_READ_EN to make counter reads destructive.
module perf_counter_reader
    import lc3b_types::*;
#(
    parameter int       NUM_COUNTERS = 8,
    parameter lc3b_word BASE_ADDR    = PERF_BASE_ADDR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  lc3b_word                count_in [NUM_COUNTERS],
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  lc3b_word                mem_address,
    input  lc3b_word                mem_wdata,
    output logic                    mem_resp,
    output lc3b_word                mem_rdata,
    output logic [NUM_COUNTERS-1:0] clear_out
);

    perf_state_t state, next_state;

    logic       hit;
    logic [3:0] index;
    logic       index_valid;

    logic       req_read;
    logic       req_clr;
    logic       req_valid;
    logic [3:0] req_index;
    lc3b_word   hold;
    lc3b_word   rd_value;
    logic [NUM_COUNTERS-1:0] sel;

    logic accept;
    logic unused_wdata;

    assign unused_wdata = ^mem_wdata[15:1];

    perf_addr_decode #(
        .NUM_COUNTERS(NUM_COUNTERS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_decode (
        .address    (mem_address),
        .hit        (hit),
        .index      (index),
        .index_valid(index_valid)
    );

    assign accept = (state == IDLE) && hit && (mem_read || mem_write);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Request fields are captured once so later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_read  <= 1'b0;
            req_clr   <= 1'b0;
            req_valid <= 1'b0;
            req_index <= 4'h0;
        end else if (accept) begin
            req_read  <= mem_read;
            req_clr   <= mem_wdata[0];
            req_valid <= index_valid;
            req_index <= index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                 hold <= '0;
        else if (state == CAPTURE) hold <= rd_value;
    end

    always_comb begin
        rd_value = '0;
        sel      = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (req_valid && req_index == 4'(i)) begin
                rd_value = count_in[i];
                sel[i]   = 1'b1;
            end
        end
        if (req_index == PERF_ID_INDEX) rd_value = 16'(NUM_COUNTERS);
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (hit && mem_read)       next_state = CAPTURE;
                else if (hit && mem_write) next_state = CLEAR;
            end
            CAPTURE: next_state = RESP;
            CLEAR:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        clear_out = '0;
        unique case (state)
            CLEAR: begin
                if (req_clr) begin
                    if (req_index == PERF_ID_INDEX) clear_out = '1;
                    else                            clear_out = sel;
                end
            end
            RESP: begin
                mem_resp = 1'b1;
                if (req_read) mem_rdata = hold;
`ifdef PERF_CLEAR_ON_READ_EN
                if (req_read) clear_out = sel;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed self-checking bench for perf_counter_reader.
module tb_perf_counter_reader;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       reset;
    lc3b_word   count_in [8];
    logic       mem_read;
    logic       mem_write;
    lc3b_word   mem_address;
    lc3b_word   mem_wdata;
    logic       mem_resp;
    lc3b_word   mem_rdata;
    logic [7:0] clear_out;

    int checks = 0;
    int errors = 0;

`ifdef PERF_CLEAR_ON_READ_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif

    perf_counter_reader #(
        .NUM_COUNTERS(8),
        .BASE_ADDR   (16'hFF00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .clear_out  (clear_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input lc3b_word a, input lc3b_word d);
        mem_read    = rd;
        mem_write   = wr;
        mem_address = a;
        mem_wdata   = d;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got %b want 0", mem_resp);
        end
        checks++;
        if (mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0000", mem_rdata);
        end
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear got %h want 00", clear_out);
        end
        step();
    endtask

    task automatic test_read();
        logic [7:0] exp_clr;
        exp_clr = COR ? 8'b0000_1000 : 8'h00;
        drive(1'b1, 1'b0, 16'hFF06, 16'h0000);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL read_n1_resp got %b want 0", mem_resp);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1) begin
            errors++;
            $display("FAIL read_n2_resp got %b want 1", mem_resp);
        end
        checks++;
        if (mem_rdata !== 16'h0042) begin
            errors++;
            $display("FAIL read_rdata got %h want 0042", mem_rdata);
        end
        checks++;
        if (clear_out !== exp_clr) begin
            errors++;
            $display("FAIL read_clear got %h want %h", clear_out, exp_clr);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL read_after got %b/%h want 0/0000",
                     mem_resp, mem_rdata);
        end
        step();
    endtask

    task automatic test_clear();
        drive(1'b0, 1'b1, 16'hFF0A, 16'h0001);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (clear_out !== 8'b0010_0000) begin
            errors++;
            $display("FAIL clr_pulse got %b want 00100000", clear_out);
        end
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL clr_n1_resp got %b want 0", mem_resp);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL clr_resp got %b/%h want 1/0000",
                     mem_resp, mem_rdata);
        end
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL clr_once got %b want 0", clear_out);
        end
        step();
        drive(1'b0, 1'b1, 16'hFF0A, 16'h0000);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL clr_nopulse got %b want 0", clear_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1) begin
            errors++;
            $display("FAIL clr0_resp got %b want 1", mem_resp);
        end
        step();
    endtask

    task automatic test_id_and_all();
        drive(1'b0, 1'b1, 16'hFF1E, 16'h0001);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (clear_out !== 8'hFF) begin
            errors++;
            $display("FAIL clr_all got %h want ff", clear_out);
        end
        step();
        step();
        drive(1'b1, 1'b0, 16'hFF1E, 16'h0000);
        step();
        idle_bus();
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h0008) begin
            errors++;
            $display("FAIL id_read got %b/%h want 1/0008",
                     mem_resp, mem_rdata);
        end
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL id_noclear got %h want 00", clear_out);
        end
        step();
        drive(1'b1, 1'b0, 16'hFF12, 16'h0000);
        step();
        idle_bus();
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL idx9_read got %b/%h want 1/0000",
                     mem_resp, mem_rdata);
        end
        step();
    endtask

    task automatic test_rw_and_miss();
        logic [7:0] exp_clr;
        int resp_seen;
        exp_clr = COR ? 8'b0000_0100 : 8'h00;
        drive(1'b1, 1'b1, 16'hFF04, 16'h0001);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL rw_noclear got %h want 00", clear_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h3333) begin
            errors++;
            $display("FAIL rw_read got %b/%h want 1/3333",
                     mem_resp, mem_rdata);
        end
        checks++;
        if (clear_out !== exp_clr) begin
            errors++;
            $display("FAIL rw_resp_clear got %h want %h", clear_out, exp_clr);
        end
        step();
        resp_seen = 0;
        drive(1'b1, 1'b0, 16'hFE04, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) resp_seen++;
            step();
        end
        idle_bus();
        checks++;
        if (resp_seen != 0) begin
            errors++;
            $display("FAIL miss_resp got %0d want 0", resp_seen);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 16'hFF06, 16'h0000);
        step();
        idle_bus();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000 ||
            clear_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid got %b/%h/%h want 0/0000/00",
                     mem_resp, mem_rdata, clear_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late got %b want 0", mem_resp);
        end
        drive(1'b1, 1'b0, 16'hFF00, 16'h0000);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_n1 got %b want 0", mem_resp);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL rst_next_read got %b/%h want 1/1111",
                     mem_resp, mem_rdata);
        end
        step();
    endtask

    task automatic test_clear_on_read();
        logic [7:0] exp_clr;
        exp_clr = COR ? 8'b0000_0010 : 8'h00;
        drive(1'b1, 1'b0, 16'hFF02, 16'h0000);
        step();
        idle_bus();
        @(negedge clk);
        checks++;
        if (clear_out !== 8'h00) begin
            errors++;
            $display("FAIL cor_n1 got %h want 00", clear_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || clear_out !== exp_clr) begin
            errors++;
            $display("FAIL cor_resp got %b/%h want 1/%h",
                     mem_resp, clear_out, exp_clr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 16'hFF08, 16'h0000);
        step();
        mem_address = 16'hFF0C;
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_first got %b/%h want 1/5555",
                     mem_resp, mem_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %b want 0", mem_resp);
        end
        step();
        idle_bus();
        step();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== 16'h7777) begin
            errors++;
            $display("FAIL b2b_second got %b/%h want 1/7777",
                     mem_resp, mem_rdata);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) count_in[i] = 16'(16'h1111 * (i + 1));
        count_in[3] = 16'h0042;
        reset = 1'b1;
        idle_bus();
        #1;
        test_reset();
        test_read();
        test_clear();
        test_id_and_all();
        test_rw_and_miss();
        test_reset_mid();
        test_clear_on_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
